// File: rtl/fifo_load_sched.sv
// fifo_load_sched: loads NUM_FIFO*DEPTH words from a single-port memory into a
// bank of per-lane FIFOs, one word at a time, then drains every lane and
// pulses done.
//
// Build option: FIFO_LOAD_SCHED_STAGGER_EN
//   defined   - systolic drain; lane i reads in drain cycles i..i+DEPTH-1,
//               so DRAIN lasts DEPTH+NUM_FIFO-1 cycles
//   undefined - all lanes read together; DRAIN lasts DEPTH cycles
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; underflow holds its last value
// REQ   | mem_rd high for one cycle, mem_addr = f*DEPTH + k
// WAIT  | waiting for mem_valid; the returned word goes to data_q
// WRITE | writes data_q into lane f, stalling while that lane is full
// DRAIN | schedules the per-lane reads; d counts drain cycles
// DONE  | done high for one cycle
//
// Every output is a flop. The next-state logic therefore computes each output
// for the state being entered. fifo_full and fifo_empty are sampled on the
// edge that starts the cycle in which the write or read happens.
module fifo_load_sched #(
  parameter int NUM_FIFO   = 8,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  underflow,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [NUM_FIFO-1:0]   fifo_wren,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic [NUM_FIFO-1:0]   fifo_full,
  output logic [NUM_FIFO-1:0]   fifo_rden,
  input  logic [NUM_FIFO-1:0]   fifo_empty
);

  localparam int FW = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
  localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(DEPTH + NUM_FIFO + 1);
`ifdef FIFO_LOAD_SCHED_STAGGER_EN
  localparam int DRAIN_LAST = DEPTH + NUM_FIFO - 2;
`else
  localparam int DRAIN_LAST = DEPTH - 1;
`endif
  localparam logic [FW-1:0] F_LAST = FW'(NUM_FIFO - 1);
  localparam logic [KW-1:0] K_LAST = KW'(DEPTH - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_LAST);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [FW-1:0]           f_q, f_d;
  logic [KW-1:0]           k_q, k_d;
  logic [DW-1:0]           d_q, d_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    uf_q, uf_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [NUM_FIFO-1:0]     wren_q, wren_d;
  logic [NUM_FIFO-1:0]     rden_q, rden_d;
  logic [NUM_FIFO-1:0]     sched;

  // Lanes that are due to read in drain cycle d.
  function automatic logic [NUM_FIFO-1:0] lanes_due(input logic [DW-1:0] d);
    logic [NUM_FIFO-1:0] due;
    due = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
`ifdef FIFO_LOAD_SCHED_STAGGER_EN
      due[i] = (int'(d) >= i) && (int'(d) < i + DEPTH);
`else
      due[i] = (int'(d) < DEPTH);
`endif
    end
    return due;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [FW-1:0] f,
                                                      input logic [KW-1:0] k);
    return ADDR_WIDTH'(f) * ADDR_WIDTH'(DEPTH) + ADDR_WIDTH'(k);
  endfunction

  // Next state, counters and the registered value of every output.
  always_comb begin
    state_d    = state_q;
    f_d        = f_q;
    k_d        = k_q;
    d_d        = d_q;
    data_d     = data_q;
    uf_d       = uf_q;
    done_d     = 1'b0;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    wren_d     = '0;
    rden_d     = '0;
    sched      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = REQ;
          f_d        = '0;
          k_d        = '0;
          uf_d       = 1'b0;
          mem_rd_d   = 1'b1;
          mem_addr_d = '0;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          data_d  = mem_rdata;
          state_d = WRITE;
          if (!fifo_full[f_q]) wren_d = NUM_FIFO'(1) << f_q;
        end
      end
      WRITE: begin
        if (|wren_q) begin
          // The word went out this cycle; move on to the next one.
          if (f_q == F_LAST && k_q == K_LAST) begin
            state_d = DRAIN;
            d_d     = '0;
            sched   = lanes_due('0);
            rden_d  = sched & ~fifo_empty;
            uf_d    = uf_q | (|(sched & fifo_empty));
          end else begin
            if (k_q == K_LAST) begin
              k_d = '0;
              f_d = f_q + 1'b1;
            end else begin
              k_d = k_q + 1'b1;
            end
            state_d    = REQ;
            mem_rd_d   = 1'b1;
            mem_addr_d = word_addr(f_d, k_d);
          end
        end else if (!fifo_full[f_q]) begin
          wren_d = NUM_FIFO'(1) << f_q;
        end
      end
      DRAIN: begin
        if (d_q == D_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          d_d    = d_q + 1'b1;
          sched  = lanes_due(d_d);
          rden_d = sched & ~fifo_empty;
          uf_d   = uf_q | (|(sched & fifo_empty));
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters and output flops; reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      f_q        <= '0;
      k_q        <= '0;
      d_q        <= '0;
      data_q     <= '0;
      uf_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      wren_q     <= '0;
      rden_q     <= '0;
    end else begin
      state_q    <= state_d;
      f_q        <= f_d;
      k_q        <= k_d;
      d_q        <= d_d;
      data_q     <= data_d;
      uf_q       <= uf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      wren_q     <= wren_d;
      rden_q     <= rden_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign underflow  = uf_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign fifo_wren  = wren_q;
  assign fifo_wdata = data_q;
  assign fifo_rden  = rden_q;

endmodule

// File: doc/fifo_load_sched.md
# fifo_load_sched

Load/drain scheduler for the bank of per-lane FIFOs that feed the compute array. On `start` it reads `NUM_FIFO*DEPTH` words from a single-port memory and writes each FIFO in turn until it holds `DEPTH` words. It then drains all FIFOs with a per-lane one-cycle stagger (systolic skew) and pulses `done`. It sits between the memory read port and the FIFO bank's `wren`/`rden` controls.

## Interface
- `NUM_FIFO`, 8: number of FIFO lanes.
- `DEPTH`, 8: words loaded into, and drained from, each FIFO.
- `DATA_WIDTH`, 8: word width.
- `ADDR_WIDTH`, 8: memory address width; must be ≥ clog2(NUM_FIFO*DEPTH).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a load/drain job; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at job end.
- `underflow`  out  1  sticky; a scheduled read found its FIFO empty.
- `mem_rd`  out  1  one-cycle read request.
- `mem_addr`  out  ADDR_WIDTH  read address, valid while `mem_rd`=1.
- `mem_valid`  in  1  read data valid, at least 1 cycle after `mem_rd`.
- `mem_rdata`  in  DATA_WIDTH  read data.
- `fifo_wren`  out  NUM_FIFO  one-hot write enable.
- `fifo_wdata`  out  DATA_WIDTH  write data, shared by all lanes.
- `fifo_full`  in  NUM_FIFO  per-lane full.
- `fifo_rden`  out  NUM_FIFO  per-lane read enable.
- `fifo_empty`  in  NUM_FIFO  per-lane empty.

## Operation
- States: IDLE, REQ, WAIT, WRITE, DRAIN, DONE.
- IDLE: if `start`=1, go to REQ. Clear lane counter `f`, word counter `k` and `underflow`.
- REQ: drive `mem_rd`=1 with `mem_addr` = f*DEPTH + k (zero-extended). Go to WAIT.
- WAIT: hold until `mem_valid`=1, then capture `mem_rdata` into the data register and go to WRITE. No further request is issued while waiting; at most one read is outstanding.
- WRITE: if `fifo_full[f]`=0, drive `fifo_wren[f]`=1 with `fifo_wdata` = the captured word, then advance.
  - If `fifo_full[f]`=1, stall in WRITE with `fifo_wren` low.
  - Advance: k++. When k wraps from DEPTH-1 to 0, f++. After the last word (f=NUM_FIFO-1, k=DEPTH-1) go to DRAIN with drain counter `d`=0; otherwise go to REQ.
- DRAIN: `fifo_rden[i]` = (d ≥ i) && (d < i+DEPTH) && !`fifo_empty[i]`.
  - A scheduled read with `fifo_empty[i]`=1 sets `underflow`. The read is skipped, not retried.
  - `d` increments every cycle. After d = DEPTH+NUM_FIFO-2, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- `fifo_wren` and `fifo_rden` are never both non-zero in the same cycle.

## Timing
- Reset values: state=IDLE, all counters 0, and `busy`, `done`, `underflow`, `mem_rd`, `mem_addr`, `fifo_wren`, `fifo_wdata`, `fifo_rden` all 0.
- Reset mid-job returns the block to IDLE immediately. FIFO contents are not cleared by this block.
- All outputs are registered.
- `busy` rises in the cycle after `start` is sampled and falls in the cycle after `done`.
- Per word: 3 cycles minimum (REQ, WAIT with 1-cycle memory latency, WRITE). Each extra cycle of memory latency or `fifo_full` stall adds one cycle.
- Fill takes at least 3*NUM_FIFO*DEPTH cycles.
- Drain takes DEPTH+NUM_FIFO-1 cycles (staggered); DONE takes 1 cycle.
- Lane i reads in drain cycles i through i+DEPTH-1.

## Configuration
- Macro `FIFO_LOAD_SCHED_STAGGER_EN`.
- Defined: staggered drain as specified above, DEPTH+NUM_FIFO-1 cycles.
- Undefined: all lanes read together. `fifo_rden[i]` = (d < DEPTH) && !`fifo_empty[i]`, and DRAIN lasts exactly DEPTH cycles.
- All other behaviour is identical in both builds.

## Test plan
Each scenario uses NUM_FIFO=2 and DEPTH=4; the memory model returns data = addr+8'h10.
- Reset, then idle 5 cycles -> all outputs 0, `busy`=0.
- `start` with 1-cycle memory latency -> `mem_addr` sequence 0..7. Lane 0 gets 8'h10–8'h13 and lane 1 gets 8'h14–8'h17. `fifo_wren` pattern: 01 ×4 writes, then 10 ×4 writes. Fill takes 24 cycles.
- Drain (stagger build) -> `fifo_rden` per cycle: 01, 11, 11, 11, 10. Then `done` pulses once and `underflow`=0.
- Drain (build without macro) -> `fifo_rden`=11 for 4 cycles, then `done`.
- Hold `fifo_full[0]`=1 for 3 cycles during the second write -> WRITE stalls 3 cycles. No write is lost and lane 0 data order is preserved.
- Force `fifo_empty[1]`=1 during drain -> lane 1 reads are suppressed and `underflow`=1 until the next `start`. Assert `rst_n`=0 mid-fill -> IDLE next cycle, outputs 0.
